// File: rtl/i2c_target_regfile.sv
// I2C target with a small MPU-6050-style register map.
// SCL and SDA are oversampled on clk_in to find START, STOP and SCL edges.
// The target matches a 7-bit address and serves byte writes and reads.
// The register pointer auto-increments after every data byte.
// SDA is driven open-drain: sda_oe=1 pulls the line low.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus free or reset; waiting for START
// ADDR      | shifting in address byte (7-bit address + R/W)
// ADDR_ACK  | holding SDA low for the address ACK
// REG       | shifting in the register pointer byte
// REG_ACK   | holding SDA low for the pointer ACK
// WDATA     | shifting in a write data byte
// WDATA_ACK | holding SDA low for the data ACK (write already committed)
// RDATA     | driving a read byte, MSB first
// RDATA_ACK | SDA released; sampling the controller's ACK/NACK
// WAIT_STOP | not addressed or read ended by NACK; waiting for STOP/START
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR   = 7'h68,
  parameter int         DEPTH         = 16,
  parameter logic [7:0] WHO_AM_I_ADDR = 8'h75,
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h68
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  state_t     state;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_h;
  logic       sda_h;
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic [7:0] tx;
  logic [7:0] ptr;
  logic       rw;
  logic       ack_n;
  logic [7:0] regs [DEPTH];
  logic [7:0] rd_byte;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  // Two-flop synchronizers plus one history stage; preset to the idle-bus level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_h    <= scl_sync[1];
      sda_h    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

  // Byte returned for the current pointer: register, identity value, or zero.
  always_comb begin
    rd_byte = 8'h00;
    if (ptr < DEPTH_B) begin
      rd_byte = regs[ptr[AW-1:0]];
    end else if (ptr == WHO_AM_I_ADDR) begin
      rd_byte = WHO_AM_I_VAL;
    end
  end

  // Bus protocol FSM: SDA sampled on SCL rise, SDA drive updated only after SCL fall.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      cnt      <= 4'd0;
      shreg    <= 8'h00;
      tx       <= 8'h00;
      ptr      <= 8'h00;
      rw       <= 1'b0;
      ack_n    <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      wr_pulse <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state  <= ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, REG, WDATA: begin
            if (cnt < 4'd8) begin
              shreg <= {shreg[6:0], sda_s};
              cnt   <= cnt + 4'd1;
            end
          end
          RDATA: begin
            if (cnt < 4'd8) cnt <= cnt + 4'd1;
          end
          ADDR_ACK, REG_ACK, WDATA_ACK, RDATA_ACK: begin
            cnt   <= 4'd9;
            ack_n <= sda_s;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: begin
            if (cnt == 4'd8) begin
              if (shreg[7:1] == TARGET_ADDR) begin
                state  <= ADDR_ACK;
                busy   <= 1'b1;
                sda_oe <= 1'b1;
                rw     <= shreg[0];
              end else begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (cnt == 4'd9) begin
              cnt <= 4'd0;
              if (rw) begin
                state  <= RDATA;
                tx     <= rd_byte;
                sda_oe <= ~rd_byte[7];
              end else begin
                state  <= REG;
                sda_oe <= 1'b0;
              end
            end
          end
          REG: begin
            if (cnt == 4'd8) begin
              ptr    <= shreg;
              state  <= REG_ACK;
              sda_oe <= 1'b1;
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (cnt == 4'd9) begin
              state  <= WDATA;
              cnt    <= 4'd0;
              sda_oe <= 1'b0;
            end
          end
          WDATA: begin
            if (cnt == 4'd8) begin
              // Unmapped and identity pointers still ACK and strobe, but store nothing.
              if (ptr < DEPTH_B) regs[ptr[AW-1:0]] <= shreg;
              wr_pulse <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= shreg;
              ptr      <= ptr + 8'd1;
              state    <= WDATA_ACK;
              sda_oe   <= 1'b1;
            end
          end
          RDATA: begin
            if (cnt == 4'd8) begin
              sda_oe <= 1'b0;
              ptr    <= ptr + 8'd1;
              state  <= RDATA_ACK;
            end else if (cnt != 4'd0) begin
              tx     <= {tx[6:0], 1'b0};
              sda_oe <= ~tx[6];
            end
          end
          RDATA_ACK: begin
            if (cnt == 4'd9) begin
              if (!ack_n) begin
                state  <= RDATA;
                cnt    <= 4'd0;
                tx     <= rd_byte;
                sda_oe <= ~rd_byte[7];
              end else begin
                state  <= WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C controller, open-drain bus,
// and a register-map model for expected read data and write strobes.
module tb_i2c_target_regfile;

  localparam int Q = 50;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       busy;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_regs [16];
  logic [7:0]  m_ptr;
  logic [15:0] pulse_q [$];
  logic [15:0] exp_q [$];

  assign sda_bus = sda_drv & ~sda_oe;

  always #5 clk_in = ~clk_in;

  i2c_target_regfile dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always @(negedge clk_in) begin
    if (wr_pulse) pulse_q.push_back({wr_addr, wr_data});
  end

  function automatic logic [7:0] m_read(input logic [7:0] p);
    if (p < 8'd16) return m_regs[p[3:0]];
    if (p == 8'h75) return 8'h68;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 8'h00;
  endtask

  task automatic model_write(input logic [7:0] d);
    exp_q.push_back({m_ptr, d});
    if (m_ptr < 8'd16) m_regs[m_ptr[3:0]] = d;
    m_ptr = m_ptr + 8'd1;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; #Q;
    scl_in  = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_in  = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #Q;
    scl_in  = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
    #(4 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; #Q;
    scl_in  = 1'b1; #(2 * Q);
    scl_in  = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    sda_drv = 1'b1; #Q;
    scl_in  = 1'b1; #Q;
    b = sda_bus; #Q;
    scl_in  = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_bit);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack_bit);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(v);
      b[i] = v;
    end
    send_bit(nack);
  endtask

  task automatic test_reset();
    logic a;
    logic [7:0] d;
    rst_n = 1'b0; scl_in = 1'b1; sda_drv = 1'b1;
    model_reset();
    repeat (5) @(negedge clk_in);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse got %b exp 0", wr_pulse); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h exp 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h exp 00", wr_data); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    i2c_start();
    send_byte(8'hD1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL reset_rd_addr_ack got %b exp 0", a); end
    recv_byte(d, 1'b1);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_rd_reg0 got %h exp 00", d); end
    m_ptr = m_ptr + 8'd1;
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after_stop got %b exp 0", busy); end
  endtask

  task automatic test_write();
    logic a;
    pulse_q.delete(); exp_q.delete();
    i2c_start();
    send_byte(8'hD0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b exp 0", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", busy); end
    send_byte(8'h03, a); m_ptr = 8'h03;
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_reg_ack got %b exp 0", a); end
    send_byte(8'hA5, a); model_write(8'hA5);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_data0_ack got %b exp 0", a); end
    send_byte(8'h5A, a); model_write(8'h5A);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_data1_ack got %b exp 0", a); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got %b exp 0", busy); end
    checks++;
    if (pulse_q.size() != 2) begin
      errors++; $display("FAIL wr_pulse_count got %0d exp 2", pulse_q.size());
    end else begin
      checks++; if (pulse_q[0] !== 16'h03A5) begin errors++; $display("FAIL wr_pulse0 got %h exp 03a5", pulse_q[0]); end
      checks++; if (pulse_q[1] !== 16'h045A) begin errors++; $display("FAIL wr_pulse1 got %h exp 045a", pulse_q[1]); end
    end
  endtask

  task automatic test_read_back();
    logic a;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hD0, a);
    send_byte(8'h03, a); m_ptr = 8'h03;
    i2c_start();
    send_byte(8'hD1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rb_addr_ack got %b exp 0", a); end
    recv_byte(d, 1'b0);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rb_byte0 got %h exp a5", d); end
    recv_byte(d, 1'b1);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rb_byte1 got %h exp 5a", d); end
    m_ptr = m_ptr + 8'd2;
    #Q;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rb_release_after_nack got %b exp 0", sda_oe); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rb_busy_after_stop got %b exp 0", busy); end
  endtask

  task automatic test_who_am_i();
    logic a;
    logic [7:0] d;
    pulse_q.delete();
    i2c_start();
    send_byte(8'hD0, a);
    send_byte(8'h75, a);
    i2c_start();
    send_byte(8'hD1, a);
    recv_byte(d, 1'b1);
    checks++; if (d !== 8'h68) begin errors++; $display("FAIL who_read got %h exp 68", d); end
    i2c_stop();
    i2c_start();
    send_byte(8'hD0, a);
    send_byte(8'h75, a);
    send_byte(8'h00, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL who_write_ack got %b exp 0", a); end
    i2c_stop();
    checks++;
    if (pulse_q.size() != 1) begin
      errors++; $display("FAIL who_pulse_count got %0d exp 1", pulse_q.size());
    end else begin
      checks++; if (pulse_q[0] !== 16'h7500) begin errors++; $display("FAIL who_pulse got %h exp 7500", pulse_q[0]); end
    end
    i2c_start();
    send_byte(8'hD0, a);
    send_byte(8'h75, a);
    i2c_start();
    send_byte(8'hD1, a);
    recv_byte(d, 1'b1);
    checks++; if (d !== 8'h68) begin errors++; $display("FAIL who_read_after_write got %h exp 68", d); end
    i2c_stop();
    m_ptr = 8'h77;
  endtask

  task automatic test_addr_nack();
    logic a;
    pulse_q.delete();
    i2c_start();
    send_byte(8'hA0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nack_addr got %b exp 1", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy got %b exp 0", busy); end
    send_byte(8'h03, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nack_reg got %b exp 1", a); end
    send_byte(8'h11, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL nack_data got %b exp 1", a); end
    i2c_stop();
    checks++; if (pulse_q.size() != 0) begin errors++; $display("FAIL nack_no_pulse got %0d exp 0", pulse_q.size()); end
  endtask

  task automatic test_wrap_and_reset();
    logic a;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hD0, a);
    send_byte(8'hFF, a); m_ptr = 8'hFF;
    i2c_start();
    send_byte(8'hD1, a);
    recv_byte(d, 1'b0);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL wrap_byte_ff got %h exp 00", d); end
    m_ptr = m_ptr + 8'd1;
    recv_byte(d, 1'b1);
    checks++; if (d !== m_read(m_ptr)) begin errors++; $display("FAIL wrap_byte_00 got %h exp %h", d, m_read(m_ptr)); end
    m_ptr = m_ptr + 8'd1;
    i2c_stop();
    // Read from an unmapped pointer so every data bit pulls SDA low, then reset mid-byte.
    i2c_start();
    send_byte(8'hD0, a);
    send_byte(8'h80, a);
    i2c_start();
    send_byte(8'hD1, a);
    recv_bit(a);
    recv_bit(a);
    #Q;
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midbyte_driving got %b exp 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midbyte_reset_sda_oe got %b exp 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midbyte_reset_busy got %b exp 0", busy); end
    @(negedge clk_in);
    sda_drv = 1'b1; scl_in = 1'b1;
    model_reset();
    repeat (5) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    i2c_start();
    send_byte(8'hD1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL post_reset_ack got %b exp 0", a); end
    recv_byte(d, 1'b1);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_reg0 got %h exp 00", d); end
    m_ptr = m_ptr + 8'd1;
    i2c_stop();
  endtask

  task automatic test_random();
    logic a;
    logic [7:0] d;
    logic [7:0] p;
    logic [7:0] e;
    int kind;
    int n;
    int sel;
    for (int t = 0; t < 18; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 4);
      sel  = $urandom_range(0, 4);
      case (sel)
        0, 1:    p = 8'($urandom_range(0, 15));
        2:       p = 8'h75;
        3:       p = 8'hFE;
        default: p = 8'($urandom_range(0, 255));
      endcase
      if (kind == 0) begin
        pulse_q.delete(); exp_q.delete();
        i2c_start();
        send_byte(8'hD0, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rnd%0d_waddr_ack got %b exp 0", t, a); end
        send_byte(p, a); m_ptr = p;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rnd%0d_reg_ack got %b exp 0", t, a); end
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          send_byte(d, a);
          model_write(d);
          checks++; if (a !== 1'b0) begin errors++; $display("FAIL rnd%0d_data%0d_ack got %b exp 0", t, k, a); end
        end
        i2c_stop();
        checks++;
        if (pulse_q.size() != exp_q.size()) begin
          errors++; $display("FAIL rnd%0d_pulse_count got %0d exp %0d", t, pulse_q.size(), exp_q.size());
        end else begin
          for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (pulse_q[k] !== exp_q[k]) begin
              errors++; $display("FAIL rnd%0d_pulse%0d got %h exp %h", t, k, pulse_q[k], exp_q[k]);
            end
          end
        end
      end else begin
        i2c_start();
        if (kind == 1) begin
          send_byte(8'hD0, a);
          send_byte(p, a); m_ptr = p;
          i2c_start();
        end
        send_byte(8'hD1, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rnd%0d_raddr_ack got %b exp 0", t, a); end
        for (int k = 0; k < n; k++) begin
          recv_byte(d, (k == n - 1) ? 1'b1 : 1'b0);
          e = m_read(m_ptr);
          checks++; if (d !== e) begin errors++; $display("FAIL rnd%0d_rd%0d ptr %h got %h exp %h", t, k, m_ptr, d, e); end
          m_ptr = m_ptr + 8'd1;
        end
        i2c_stop();
      end
    end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_write();
    test_read_back();
    test_who_am_i();
    test_addr_nack();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
